sram_arbiter_wfifo: RTL and testbench
=====================================

// Module: sram_arbiter_wfifo
// PURPOSE
// Time-slot arbiter sharing one asynchronous SRAM between the VGA-side writer and CGA-side reader of the scan converter.
// Generalised successor of the single-buffer memory block: parametrised data/address width.
// Adds a write FIFO so back-to-back VGA writes are not lost.
// Adds a write-run limit so the CGA reader is never starved, and a sticky overflow flag.
// Each memory access occupies one 4-clock slot (T0..T3).
// PARAMETERS
// DATA_W      8   data width of dVga, dCga, dMem
// ADDR_W      16  address width of aVga, aCga, aMem (all bits driven)
// FIFO_DEPTH  4   write FIFO entries; power of 2, >= 2
// MAX_WR_RUN  3   max consecutive write slots before one read slot is forced; >= 1
// PORTS
// clk         in   1        system clock; all logic on rising edge
// reset       in   1        asynchronous, active-low reset (0 = reset)
// wrVga       in   1        VGA write strobe, active low, synchronous to clk
// aVga        in   ADDR_W   VGA write address
// dVga        in   DATA_W   VGA write data
// aCga        in   ADDR_W   CGA read address, sampled at slot start
// dCga        out  DATA_W   last read data, held between reads
// rdStrobe    out  1        1-clk pulse: dCga just updated
// aMem        out  ADDR_W   SRAM address
// dMem        inout DATA_W  SRAM data; driven only in write slots
// _csMem      out  1        SRAM chip select, active low
// _oeMem      out  1        SRAM output enable, active low
// _weMem      out  1        SRAM write enable, active low
// t3          out  1        1 while phase==3
// halfclk     out  1        phase[0]
// wrPending   out  1        FIFO non-empty
// wrOverflow  out  1        sticky: a write was dropped because FIFO full
// BEHAVIOUR
// Reset (async, reset=0): phase=0, slot=IDLE, FIFO empty, wrRun=0, dCga=0, rdStrobe=0, wrOverflow=0.
// Reset forces all strobes=1, dMem=Z, aMem=0, t3=0, halfclk=0. Reset mid-slot aborts the access immediately.
// Phase counter: 2 bits, 0->1->2->3->0 every clk, free running.
// Slot decision on the edge leaving phase 3:
//   if FIFO non-empty and wrRun<MAX_WR_RUN: slot=WRITE, pop head into slot addr/data regs, wrRun++.
//   else: slot=READ, latch aCga into slot addr reg, wrRun=0.
// First slot after reset release is IDLE: no strobes, no capture.
// aMem = slot addr reg for the whole slot; stable phases 0..3.
// Strobes are flop outputs, decoded from next phase/slot:
//   _csMem=0 in phases 1,2,3 of READ/WRITE slots.
//   _oeMem=0 in phases 1,2,3 of READ slots.
//   _weMem=0 in phases 1,2 of WRITE slots; high in phase 3 gives data hold.
// dMem = slot data for phases 0..3 of WRITE slots; Z otherwise. Never driven while _oeMem=0.
// Read capture: on the edge leaving phase 3 of a READ slot, dCga<=dMem. rdStrobe=1 for the next clk only.
// Write capture:
//   each clk with wrVga=0, aVga/dVga load a staging reg.
//   On the first clk wrVga=1 after wrVga=0 (rising edge), staging is pushed.
// Push when FIFO full: entry dropped, FIFO unchanged, wrOverflow<=1 until reset.
// Push and pop on the same edge: both take effect; a pop frees space for that push, so no overflow.
// Writes retire in FIFO order. Worst-case read latency: (MAX_WR_RUN+1) slots = 4*(MAX_WR_RUN+1) clks.
// Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
// TESTING
// Reset low mid-slot -> all strobes 1, dMem Z, dCga=0, wrOverflow=0, phase=0 within same cycle (async).
// No writes, aCga=16'h0123, SRAM model returns 8'hA5:
//   aMem=0123 each read slot, _oeMem low phases 1-3, dCga=A5, one rdStrobe per 4 clks.
// Single write aVga=16'h0040, dVga=8'h3C:
//   next slot is WRITE, _weMem low exactly 2 clks, dMem=3C, model mem[0040]=3C; following slot is READ.
// 5 writes back-to-back, default params:
//   4 retired in order as W,W,W,R,W; 5th accepted only if a pop freed space, else wrOverflow=1 and stays 1.
// Continuous writes: never more than 3 consecutive WRITE slots; rdStrobe at least every 16 clks.
// Assertion throughout: dMem never driven while _oeMem=0; _weMem and _oeMem never both 0.

Source files
------------

// File: rtl/sram_arbiter_wfifo.sv
// sram_arbiter_wfifo: 4-clock time-slot arbiter sharing one async SRAM between a FIFO-buffered
// VGA writer and a CGA reader, with a write-run limit and a sticky overflow flag.
module sram_arbiter_wfifo #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WR_RUN = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrVga,
    input  logic [ADDR_W-1:0] aVga,
    input  logic [DATA_W-1:0] dVga,
    input  logic [ADDR_W-1:0] aCga,
    output logic [DATA_W-1:0] dCga,
    output logic              rdStrobe,
    output logic [ADDR_W-1:0] aMem,
    inout  wire  [DATA_W-1:0] dMem,
    output logic              _csMem,
    output logic              _oeMem,
    output logic              _weMem,
    output logic              t3,
    output logic              halfclk,
    output logic              wrPending,
    output logic              wrOverflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RUN_W = $clog2(MAX_WR_RUN + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_WR_RUN);

    typedef enum logic [1:0] {IDLE, READ, WRITE} slot_t;

    slot_t slot_q, slot_d;
    logic [1:0] phase_q, phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W+DATA_W-1:0] stg_q, stg_d;
    logic [ADDR_W+DATA_W-1:0] fifo_q [FIFO_DEPTH];
    logic [DATA_W-1:0] dcga_q, dcga_d;
    logic wr_prev_q, wr_prev_d, ovf_q, ovf_d, rds_q, rds_d;
    logic csn_q, csn_d, oen_q, oen_d, wen_q, wen_d;
    logic slot_end, pop, push, accept;

    always_comb begin
        slot_end  = phase_q == 2'd3;
        pop       = slot_end && cnt_q != '0 && run_q < RUN_MAX;
        push      = wrVga && !wr_prev_q;
        // a pop on the same edge frees the slot the push needs
        accept    = push && (cnt_q != FULL || pop);
        phase_d   = phase_q + 2'd1;
        slot_d    = slot_end ? (pop ? WRITE : READ) : slot_q;
        addr_d    = slot_end ? (pop ? fifo_q[rd_ptr_q][ADDR_W+DATA_W-1:DATA_W] : aCga) : addr_q;
        data_d    = pop ? fifo_q[rd_ptr_q][DATA_W-1:0] : data_q;
        run_d     = slot_end ? (pop ? run_q + 1'b1 : '0) : run_q;
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d  = wr_ptr_q + PTR_W'(accept);
        cnt_d     = cnt_q + CNT_W'(accept) - CNT_W'(pop);
        stg_d     = !wrVga ? {aVga, dVga} : stg_q;
        wr_prev_d = wrVga;
        ovf_d     = ovf_q || (push && !accept);
        rds_d     = slot_end && slot_q == READ;
        dcga_d    = rds_d ? dMem : dcga_q;
        // strobes are registered from the next phase/slot so they line up with phase_q
        csn_d     = !(slot_d != IDLE && phase_d != 2'd0);
        oen_d     = !(slot_d == READ && phase_d != 2'd0);
        wen_d     = !(slot_d == WRITE && (phase_d == 2'd1 || phase_d == 2'd2));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q   <= '0;
            slot_q    <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            run_q     <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            stg_q     <= '0;
            wr_prev_q <= 1'b1;
            ovf_q     <= 1'b0;
            rds_q     <= 1'b0;
            dcga_q    <= '0;
            csn_q     <= 1'b1;
            oen_q     <= 1'b1;
            wen_q     <= 1'b1;
        end else begin
            phase_q   <= phase_d;
            slot_q    <= slot_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            run_q     <= run_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            stg_q     <= stg_d;
            wr_prev_q <= wr_prev_d;
            ovf_q     <= ovf_d;
            rds_q     <= rds_d;
            dcga_q    <= dcga_d;
            csn_q     <= csn_d;
            oen_q     <= oen_d;
            wen_q     <= wen_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) fifo_q[wr_ptr_q] <= stg_q;
    end

    assign dMem       = slot_q == WRITE ? data_q : {DATA_W{1'bz}};
    assign aMem       = addr_q;
    assign dCga       = dcga_q;
    assign rdStrobe   = rds_q;
    assign _csMem     = csn_q;
    assign _oeMem     = oen_q;
    assign _weMem     = wen_q;
    assign t3         = phase_q == 2'd3;
    assign halfclk    = phase_q[0];
    assign wrPending  = cnt_q != '0;
    assign wrOverflow = ovf_q;
endmodule

// File: tb/tb_sram_arbiter_wfifo.sv
// tb_sram_arbiter_wfifo: randomized scoreboard bench; a queue-level slot model predicts every
// SRAM access and read result, and a negedge monitor pops and compares as the DUT presents them.
module tb_sram_arbiter_wfifo;
    localparam int DEPTH = 4;
    localparam int MAXRUN = 3;

    typedef struct packed {logic wr; logic [15:0] a; logic [7:0] d;} slot_e;

    logic clk = 0, reset = 1, wrVga = 1;
    logic [15:0] aVga = 0, aCga = 16'h0123, aMem;
    logic [7:0] dVga = 0, dCga;
    wire  [7:0] dMem;
    logic rdStrobe, csn, oen, wen, t3, halfclk, wrPending, wrOverflow;

    logic [7:0] sram [0:65535];
    logic [7:0] ref_mem [0:65535];
    int errors = 0, checks = 0;

    sram_arbiter_wfifo dut (
        .clk(clk), .reset(reset), .wrVga(wrVga), .aVga(aVga), .dVga(dVga), .aCga(aCga),
        .dCga(dCga), .rdStrobe(rdStrobe), .aMem(aMem), .dMem(dMem), ._csMem(csn),
        ._oeMem(oen), ._weMem(wen), .t3(t3), .halfclk(halfclk), .wrPending(wrPending),
        .wrOverflow(wrOverflow)
    );

    always #5 clk = ~clk;

    // SRAM model; during reset the bench parks a known pattern on the otherwise floating bus
    assign dMem = !reset ? 8'h5A : (!csn && !oen) ? sram[aMem] : 8'hzz;
    always @(posedge wen) if (reset && !csn) sram[aMem] <= dMem;

    task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: slot boundary every 4 clocks, pending writes as a plain queue
    slot_e exp_slots[$];
    logic [7:0] exp_rd[$];
    logic [23:0] m_fifo[$];
    logic [23:0] m_stg = 0, m_e;
    slot_e m_s;
    int m_phase = 0, m_run = 0;
    logic m_ovf = 0, m_prev = 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_slots.delete();
            exp_rd.delete();
            m_fifo.delete();
            m_phase = 0;
            m_run = 0;
            m_ovf = 0;
            m_prev = 1;
        end else begin
            if (m_phase == 3) begin
                if (m_fifo.size() > 0 && m_run < MAXRUN) begin
                    m_e = m_fifo.pop_front();
                    ref_mem[m_e[23:8]] = m_e[7:0];
                    m_s = {1'b1, m_e};
                    m_run++;
                end else begin
                    m_s = {1'b0, aCga, 8'h00};
                    exp_rd.push_back(ref_mem[aCga]);
                    m_run = 0;
                end
                exp_slots.push_back(m_s);
            end
            if (!wrVga) m_stg = {aVga, dVga};
            else if (!m_prev) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(m_stg);
                else m_ovf = 1;
            end
            m_prev = wrVga;
            m_phase = (m_phase + 1) % 4;
        end
    end

    // monitor
    logic prev_cs = 1, cur_wr = 0, gap_ok = 0;
    int we_cnt = 0, run_cnt = 0, gap = 0;
    slot_e s;
    logic [7:0] r;

    always @(negedge clk) begin
        if (!reset) begin
            prev_cs = 1; cur_wr = 0; gap_ok = 0; we_cnt = 0; run_cnt = 0; gap = 0;
        end else begin
            check_eq("we_oe_both_low", 32'(!wen && !oen), 0);
            if (!oen) check_eq("read_bus_value", 32'(dMem), 32'(sram[aMem]));
            check_eq("t3", 32'(t3), 32'(m_phase == 3));
            check_eq("halfclk", 32'(halfclk), 32'(m_phase % 2));
            check_eq("wrPending", 32'(wrPending), 32'(m_fifo.size() != 0));
            check_eq("wrOverflow", 32'(wrOverflow), 32'(m_ovf));
            if (!csn && prev_cs) begin
                we_cnt = 0;
                check_eq("access_expected", 32'(exp_slots.size() != 0), 1);
                if (exp_slots.size() != 0) begin
                    s = exp_slots.pop_front();
                    cur_wr = s.wr;
                    check_eq("slot_kind", 32'({!wen, !oen}), s.wr ? 2 : 1);
                    check_eq("slot_addr", 32'(aMem), 32'(s.a));
                    if (s.wr) check_eq("slot_wdata", 32'(dMem), 32'(s.d));
                end
                run_cnt = !wen ? run_cnt + 1 : 0;
                check_eq("write_run_over_max", 32'(run_cnt > MAXRUN), 0);
            end
            if (!wen) we_cnt++;
            if (csn && !prev_cs && cur_wr) check_eq("we_low_clks", we_cnt, 2);
            prev_cs = csn;
            gap++;
            if (rdStrobe) begin
                check_eq("read_expected", 32'(exp_rd.size() != 0), 1);
                if (exp_rd.size() != 0) begin
                    r = exp_rd.pop_front();
                    check_eq("dCga", 32'(dCga), 32'(r));
                end
                if (gap_ok) check_eq("read_gap_over_16", 32'(gap > 16), 0);
                gap = 0;
                gap_ok = 1;
            end
        end
    end

    task automatic check_reset_state();
        check_eq("rst_csMem", 32'(csn), 1);
        check_eq("rst_oeMem", 32'(oen), 1);
        check_eq("rst_weMem", 32'(wen), 1);
        check_eq("rst_aMem", 32'(aMem), 0);
        check_eq("rst_dMem_released", 32'(dMem), 32'h5A);
        check_eq("rst_dCga", 32'(dCga), 0);
        check_eq("rst_rdStrobe", 32'(rdStrobe), 0);
        check_eq("rst_wrOverflow", 32'(wrOverflow), 0);
        check_eq("rst_wrPending", 32'(wrPending), 0);
        check_eq("rst_t3", 32'(t3), 0);
        check_eq("rst_halfclk", 32'(halfclk), 0);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int lo, input int hi);
        for (int k = 0; k < lo; k++) begin
            @(negedge clk);
            wrVga = 0;
            aVga = (k == lo - 1) ? a : 16'($urandom);
            dVga = (k == lo - 1) ? d : 8'($urandom);
        end
        for (int k = 0; k < hi; k++) begin
            @(negedge clk);
            wrVga = 1;
        end
    endtask

    task automatic random_traffic(input int n, input int hi_max);
        for (int i = 0; i < n; i++) begin
            aCga = 16'($urandom_range(0, 31));
            do_write(16'($urandom_range(0, 31)), 8'($urandom), $urandom_range(1, 3),
                     $urandom_range(1, hi_max));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int i = 0; i < 65536; i++) begin
            sram[i] = 8'(i * 7 + 3);
            ref_mem[i] = sram[i];
        end
        sram[16'h0123] = 8'hA5;
        ref_mem[16'h0123] = 8'hA5;
        #2 reset = 0;
        #1 check_reset_state();
        repeat (3) @(negedge clk);
        reset = 1;
        repeat (48) @(negedge clk);
        check_eq("idle_read_A5", 32'(dCga), 32'hA5);
        do_write(16'h0040, 8'h3C, 1, 1);
        repeat (32) @(negedge clk);
        check_eq("sram_0040", 32'(sram[16'h0040]), 32'h3C);
        aCga = 16'h0040;
        repeat (16) @(negedge clk);
        check_eq("readback_0040", 32'(dCga), 32'h3C);
        for (int i = 0; i < 5; i++) do_write(16'h0100 + 16'(i), 8'h80 + 8'(i), 1, 1);
        repeat (40) @(negedge clk);
        for (int i = 0; i < 8; i++) do_write(16'h0200 + 16'(i), 8'hC0 + 8'(i), 1, 1);
        repeat (40) @(negedge clk);
        check_eq("overflow_sticky", 32'(wrOverflow), 1);
        random_traffic(300, 6);
        do_write(16'h0010, 8'h11, 1, 1);
        w = 0;
        while (wen !== 1'b0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check_eq("found_write_slot", 32'(wen), 0);
        @(posedge clk);
        #1 reset = 0;
        #1 check_reset_state();
        repeat (2) @(negedge clk);
        reset = 1;
        random_traffic(200, 10);
        repeat (40) @(negedge clk);
        check_eq("no_lost_slots", 32'(exp_slots.size() > 1), 0);
        check_eq("no_lost_reads", 32'(exp_rd.size() > 2), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
